// File: rtl/ber_checker.sv
// Bit-error-rate checker: finds the reference-to-receive alignment tap, then
// counts samples and errors while locked, dropping lock on a bad window.
module ber_checker #(
    parameter int NB_COUNT = 64,
    parameter int NB_DELAY = 9,
    parameter int NB_WIN   = 9,
    parameter int LOSS_THR = 128
) (
    input  logic                clk,
    input  logic                i_rstn,
    input  logic                i_enb,
    input  logic                i_ref_bit,
    input  logic                i_rx_bit,
    input  logic                i_clear,
    output logic [NB_COUNT-1:0] o_ber_samp,
    output logic [NB_COUNT-1:0] o_ber_error,
    output logic                o_locked,
    output logic [NB_DELAY-1:0] o_delay
);

    // state  | meaning
    // SEARCH | stepping the tap index one window at a time, counters frozen
    // LOCK   | aligned; accumulating samples/errors, watching for loss
    typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_t;

    localparam int NTAPS = 2 ** NB_DELAY;

    state_t              state;
    state_t              state_next;
    logic [NTAPS-1:0]    taps;
    logic [NB_DELAY-1:0] delay;
    logic [NB_WIN-1:0]   win_cnt;
    logic [NB_WIN:0]     win_err;
    logic [NB_WIN:0]     win_total;
    logic                mismatch;
    logic                win_last;
    logic                win_clean;
    logic                win_lost;
    logic                step_delay;

    assign mismatch  = i_rx_bit ^ taps[delay];
    assign win_last  = &win_cnt;
    assign win_total = win_err + (NB_WIN + 1)'(mismatch);
    assign win_clean = (win_total == '0);
    // Zero-extend to 32 bits so the threshold compare is unsigned and width-matched.
    assign win_lost  = ({{(31 - NB_WIN){1'b0}}, win_total} > LOSS_THR);
    assign step_delay = i_enb && win_last &&
                        (((state == SEARCH) && !win_clean) || ((state == LOCK) && win_lost));

    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            state <= SEARCH;
        end else if (i_clear) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_enb && win_last) begin
            case (state)
                SEARCH:  if (win_clean) state_next = LOCK;
                LOCK:    if (win_lost)  state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
    end

    always_comb begin
        o_locked = (state == LOCK);
        o_delay  = delay;
    end

    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            taps        <= '0;
            delay       <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_ber_samp  <= '0;
            o_ber_error <= '0;
        end else if (i_clear) begin
            // Delay line keeps its history so a restarted search has valid taps.
            delay       <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_ber_samp  <= '0;
            o_ber_error <= '0;
        end else if (i_enb) begin
            taps <= {taps[NTAPS-2:0], i_ref_bit};
            if (win_last) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_cnt + NB_WIN'(1);
                win_err <= win_total;
            end
            if (step_delay) begin
                delay <= delay + NB_DELAY'(1);
            end
            if (state == LOCK) begin
                if (o_ber_samp != '1) begin
                    o_ber_samp <= o_ber_samp + NB_COUNT'(1);
                end
                if (mismatch && (o_ber_error != '1)) begin
                    o_ber_error <= o_ber_error + NB_COUNT'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: directed table, test-plan sequences and
// randomized traffic against a queue-based reference model.
module tb_ber_checker;

    localparam int WIN   = 512;
    localparam int NTAP  = 512;
    localparam int THR   = 128;
    localparam logic [63:0] CMAX = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        i_rstn, i_enb, i_ref_bit, i_rx_bit, i_clear;
    logic [63:0] o_ber_samp, o_ber_error;
    logic        o_locked;
    logic [8:0]  o_delay;

    logic        s_rstn, s_enb, s_ref, s_rx, s_clear;
    logic [7:0]  s_samp, s_err;
    logic        s_locked;
    logic [8:0]  s_delay;

    ber_checker dut (
        .clk(clk), .i_rstn(i_rstn), .i_enb(i_enb), .i_ref_bit(i_ref_bit),
        .i_rx_bit(i_rx_bit), .i_clear(i_clear), .o_ber_samp(o_ber_samp),
        .o_ber_error(o_ber_error), .o_locked(o_locked), .o_delay(o_delay)
    );

    ber_checker #(.NB_COUNT(8), .LOSS_THR(512)) dut_sat (
        .clk(clk), .i_rstn(s_rstn), .i_enb(s_enb), .i_ref_bit(s_ref),
        .i_rx_bit(s_rx), .i_clear(s_clear), .o_ber_samp(s_samp),
        .o_ber_error(s_err), .o_locked(s_locked), .o_delay(s_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit              hist[$];
    bit              m_locked;
    int              m_delay, m_wcnt, m_werr;
    logic [63:0]     m_samp, m_err;

    // Stimulus generator state
    logic [8:0] lfsr = 9'h1FF;
    bit         sent[$];
    int         rx_dly = 5;
    int         n_enb  = 0;

    typedef struct {
        bit rstn; bit enb; bit refb; bit rx; bit clr;
        bit exp_locked; int exp_delay; int exp_samp; int exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rstn, input bit enb, input bit refb, input bit rx, input bit clr);
        bit mm;
        int total;
        if (!rstn) begin
            m_locked = 0; m_delay = 0; m_wcnt = 0; m_werr = 0; m_samp = 0; m_err = 0;
            hist.delete();
            for (int k = 0; k < NTAP; k++) hist.push_back(1'b0);
        end else if (clr) begin
            m_locked = 0; m_delay = 0; m_wcnt = 0; m_werr = 0; m_samp = 0; m_err = 0;
        end else if (enb) begin
            mm = rx ^ hist[m_delay];
            if (m_locked) begin
                if (m_samp != CMAX) m_samp = m_samp + 1;
                if (mm && m_err != CMAX) m_err = m_err + 1;
            end
            total = m_werr + int'(mm);
            if (m_wcnt == WIN - 1) begin
                if (!m_locked) begin
                    if (total == 0) m_locked = 1;
                    else m_delay = (m_delay + 1) % NTAP;
                end else if (total > THR) begin
                    m_locked = 0;
                    m_delay  = (m_delay + 1) % NTAP;
                end
                m_wcnt = 0;
                m_werr = 0;
            end else begin
                m_wcnt++;
                m_werr = total;
            end
            hist.push_front(refb);
            void'(hist.pop_back());
        end
    endtask

    task automatic cyc(input bit rstn, input bit enb, input bit refb, input bit rx, input bit clr);
        i_rstn = rstn; i_enb = enb; i_ref_bit = refb; i_rx_bit = rx; i_clear = clr;
        @(posedge clk);
        model_step(rstn, enb, refb, rx, clr);
        #1;
        check("model_samp",   o_ber_samp,  m_samp);
        check("model_err",    o_ber_error, m_err);
        check("model_locked", 64'(o_locked), 64'(m_locked));
        check("model_delay",  64'(o_delay),  64'(m_delay));
    endtask

    // Drives one cycle of PRBS traffic; rx is the reference delayed by rx_dly
    // consumed samples, optionally inverted.
    task automatic send(input bit rstn, input bit enb, input bit clr, input bit flip);
        bit refb, rx;
        refb = lfsr[8] ^ lfsr[4];
        rx   = ((sent.size() >= rx_dly) ? sent[rx_dly - 1] : 1'b0) ^ flip;
        cyc(rstn, enb, refb, rx, clr);
        if (!rstn) begin
            sent.delete();
        end else if (enb && !clr) begin
            sent.push_front(refb);
            if (sent.size() > 16) void'(sent.pop_back());
            lfsr = {lfsr[7:0], refb};
        end
        if (!rstn || clr) n_enb = 0;
        else if (enb) n_enb++;
    endtask

    task automatic cyc2(input bit rstn, input bit enb, input bit refb, input bit rx);
        s_rstn = rstn; s_enb = enb; s_ref = refb; s_rx = rx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ninv;
        int enb_at_loss;
        logic [63:0] err_at_drop, samp_at_drop;
        bit prev;
        bit b;

        s_rstn = 0; s_enb = 0; s_ref = 0; s_rx = 0; s_clear = 0;
        tbl[0] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].rstn, tbl[i].enb, tbl[i].refb, tbl[i].rx, tbl[i].clr);
            check("tbl_locked", 64'(o_locked), 64'(tbl[i].exp_locked));
            check("tbl_delay",  64'(o_delay),  64'(tbl[i].exp_delay));
            check("tbl_samp",   o_ber_samp,    64'(tbl[i].exp_samp));
            check("tbl_err",    o_ber_error,   64'(tbl[i].exp_err));
        end

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check("rst_outputs_zero", {o_ber_samp | o_ber_error} | 64'({o_locked, o_delay}), 64'd0);
        end
        sent.delete();
        n_enb = 0;
        for (int i = 0; i < 100; i++) send(1, 0, 0, 0);
        check("idle_outputs_zero", {o_ber_samp | o_ber_error} | 64'({o_locked, o_delay}), 64'd0);

        // Alignment with rx = ref delayed 5 samples: lock after 5 windows at tap 4
        rx_dly = 5;
        for (int i = 0; i < 5 * WIN; i++) begin
            send(1, 1, 0, 0);
            if (i == 5 * WIN - 2) check("align_not_early", 64'(o_locked), 64'd0);
        end
        check("align_locked", 64'(o_locked), 64'd1);
        check("align_delay",  64'(o_delay),  64'd4);
        for (int i = 0; i < 1000; i++) send(1, 1, 0, 0);
        check("align_samp_1000", o_ber_samp,  64'd1000);
        check("align_err_0",     o_ber_error, 64'd0);

        for (int i = 0; i < 300; i++) send(1, 1, 0, (i == 50) || (i == 150) || (i == 250));
        check("single_err_3",      o_ber_error, 64'd3);
        check("single_locked",     64'(o_locked), 64'd1);
        check("single_delay",      64'(o_delay),  64'd4);
        check("single_samp_1300",  o_ber_samp,  64'd1300);

        // Continuous inversion: lock drops on the current window's last sample
        enb_at_loss = 5 * WIN + 1300;
        ninv = 0;
        while (o_locked && ninv < 600) begin
            send(1, 1, 0, 1);
            ninv++;
        end
        check("loss_dropped_in_budget", 64'(o_locked), 64'd0);
        check("loss_at_window_end", 64'(ninv), 64'(WIN - (enb_at_loss % WIN)));
        check("loss_delay_5",  64'(o_delay),   64'd5);
        check("loss_err",      o_ber_error,    64'(3 + ninv));
        err_at_drop  = o_ber_error;
        samp_at_drop = o_ber_samp;
        for (int i = 0; i < 100; i++) send(1, 1, 0, 1);
        check("loss_err_frozen",  o_ber_error, err_at_drop);
        check("loss_samp_frozen", o_ber_samp,  samp_at_drop);

        // Clear, then strobe every 4th clock
        send(1, 0, 1, 0);
        check("clear_samp", o_ber_samp, 64'd0);
        check("clear_delay", 64'(o_delay), 64'd0);
        for (int i = 0; i < 5 * WIN; i++) begin
            for (int g = 0; g < 3; g++) send(1, 0, 0, 0);
            send(1, 1, 0, 0);
        end
        check("gap_relock",       64'(o_locked), 64'd1);
        check("gap_relock_delay", 64'(o_delay),  64'd4);
        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < 3; g++) send(1, 0, 0, 0);
            send(1, 1, 0, 0);
        end
        check("gap_samp_40", o_ber_samp, 64'd40);

        send(1, 1, 1, 0);
        check("clr_enb_samp",   o_ber_samp,     64'd0);
        check("clr_enb_err",    o_ber_error,    64'd0);
        check("clr_enb_locked", 64'(o_locked),  64'd0);
        check("clr_enb_delay",  64'(o_delay),   64'd0);
        for (int i = 0; i < 5 * WIN - 1; i++) send(1, 1, 0, 0);
        check("clr_no_early_lock", 64'(o_locked), 64'd0);
        send(1, 1, 0, 0);
        check("clr_relock",       64'(o_locked), 64'd1);
        check("clr_relock_delay", 64'(o_delay),  64'd4);

        // Randomized traffic, rx aligned to tap 0 with segment-dependent error rates
        rx_dly = 1;
        send(0, 0, 0, 0);
        for (int i = 0; i < 8000; i++) begin
            bit flip;
            int seg;
            seg  = i / 1200;
            flip = (seg % 3 == 2) ? 1'($urandom_range(1)) : ($urandom_range(31) == 0);
            send(($urandom_range(4000) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(900) == 0), flip);
        end

        // Saturation instance: 8-bit counters, loss threshold out of reach
        i_enb = 0; i_clear = 0;
        cyc2(0, 0, 0, 0);
        prev = 0;
        for (int i = 0; i < WIN; i++) begin
            b = 1'($urandom);
            cyc2(1, 1, b, prev);
            prev = b;
        end
        check("sat_locked", 64'(s_locked), 64'd1);
        check("sat_samp_start", 64'(s_samp), 64'd0);
        for (int i = 0; i < 300; i++) begin
            b = 1'($urandom);
            cyc2(1, 1, b, prev ^ 1'(i % 2));
            prev = b;
        end
        check("sat_samp_255", 64'(s_samp), 64'd255);
        check("sat_err_150",  64'(s_err),  64'd150);
        check("sat_still_locked", 64'(s_locked), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Bit-error-rate checker inside the receive path of DSP, one instance per branch (I and Q).
- Consumes the transmitted PRBS reference bit and the received slicer decision at the symbol rate.
- Searches for the reference-to-receive alignment delay, then accumulates sample and error counts.
- Its 64-bit counters drive the ber_samp/ber_error buses read by registerFile.

Parameters:
NB_COUNT, 64, width of sample and error counters
NB_DELAY, 9, delay-line depth is 2**NB_DELAY taps; width of o_delay
NB_WIN, 9, alignment/loss-check window length is 2**NB_WIN enabled samples
LOSS_THR, 128, window error count strictly above which lock is dropped

Ports:
clk  in  1  system clock
i_rstn  in  1  reset, synchronous, active low
i_enb  in  1  sample strobe; all state advances only when high
i_ref_bit  in  1  transmitted PRBS bit
i_rx_bit  in  1  received hard decision
i_clear  in  1  synchronous clear of counters and restart of search
o_ber_samp  out  NB_COUNT  samples counted while locked
o_ber_error  out  NB_COUNT  errors counted while locked
o_locked  out  1  high in LOCK state
o_delay  out  NB_DELAY  current alignment tap index

Behaviour:
- Reset: one clock, synchronous, active-low (clk, i_rstn). While i_rstn=0 at a clk edge:
  - all outputs go to 0, state SEARCH, delay 0, window counters 0;
  - delay line cleared to 0.
- Delay line: 2**NB_DELAY-bit shift register. On each i_enb it shifts in i_ref_bit at tap 0.
  - tap k holds the reference bit from k+1 enabled samples earlier.
- Compare: mismatch = i_rx_bit XOR tap[delay], evaluated in the i_enb cycle using pre-shift tap contents.
- Window: win_cnt counts enabled samples 0..2**NB_WIN-1, and win_err counts mismatches in the window.
  - The "last sample" is the one with win_cnt = 2**NB_WIN-1.
  - Its own mismatch is included in the window decision.
  - Both counters reset to 0 after the last sample.
- SEARCH:
  - Counters hold (not cleared).
  - On the last sample of a window:
    - if total window errors = 0, go to LOCK and keep delay;
    - else delay <= delay+1, wrapping from 2**NB_DELAY-1 to 0, and stay in SEARCH.
- LOCK: on each i_enb:
  - o_ber_samp += 1;
  - o_ber_error += mismatch;
  - window counting continues.
  - On the last sample of a window, if total window errors > LOSS_THR:
    - go to SEARCH with delay <= delay+1 (same wrap);
    - o_ber_* keep their accumulated values.
- Saturation: both counters saturate at all-ones with no wrap. When the sample counter saturates, the error counter still increments until it saturates.
- Latency: outputs are registered and reflect an enabled sample one clk after the i_enb cycle. o_locked and o_delay change in the clk after the deciding last sample.
- i_enb low: no state, counter, or delay-line change.
- i_clear=1 (i_rstn=1):
  - next clk: counters 0, window counters 0, SEARCH, delay 0;
  - delay line is NOT cleared, but does not shift that cycle;
  - i_clear overrides a simultaneous i_enb.
- Reset has priority over i_clear.
- A reset mid-window or mid-lock discards all progress.

Test Plan:
- Reset:
  - Stimulus: i_rstn=0 for 3 clk with random inputs.
  - Required response: all outputs 0; after release with i_enb=0 for 100 clk, outputs remain 0.
- Alignment:
  - Stimulus: i_enb every clk, ref = PRBS9, rx = ref delayed 5 enabled samples.
  - Required response: o_locked rises after exactly 5*512 enables with o_delay=4; after 1000 further enables o_ber_samp=1000 and o_ber_error=0.
- Single error while locked:
  - Stimulus: flip rx on 3 isolated samples.
  - Required response: o_ber_error=3, o_locked stays 1, o_delay unchanged.
- Loss of lock:
  - Stimulus: after lock, invert rx continuously.
  - Required response: at the first window end, o_locked=0 and o_delay=5; o_ber_error equals the inverted samples counted before the drop, and then freezes.
- Strobe gaps and clear:
  - Stimulus: i_enb every 4th clk, then i_clear and i_enb asserted in the same cycle while locked.
  - Required response: counts increment once per strobe only; one clk after i_clear, counters=0, o_locked=0, o_delay=0; relock occurs after the correct number of windows.
- Saturation:
  - Stimulus: NB_COUNT=8, locked, 300 enables with rx inverted every 2nd sample (LOSS_THR=512 override).
  - Required response: o_ber_samp holds 255; o_ber_error reaches 150.
